// File: rtl/queue_sched_ctrl.sv
// queue_sched_ctrl: sequences deserializer words into the output queue and
// schedules periodic dequeues, round-robin when both compete.
module queue_sched_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DEQ_PERIOD = 4
) (
  input  logic             clock_10,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid_in,
  output logic             word_ack_out,
  output logic             ser_busy_out,
  input  logic             drain_en_in,
  input  logic [7:0]       q_len_in,
  input  logic [WIDTH-1:0] q_data_in,
  output logic [WIDTH-1:0] q_data_out,
  output logic             q_enq_out,
  output logic             q_deq_out,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid_out
);

  localparam int unsigned   TW       = (DEQ_PERIOD > 1) ? $clog2(DEQ_PERIOD) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(DEQ_PERIOD - 1);
  localparam logic [7:0]    LEN_FULL = 8'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ENQ, S_DEQ, S_SETTLE} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            deq_pend_q, deq_pend_d;
  logic            last_enq_q, last_enq_d;   // 1: last grant was ENQ, 0: DEQ

  logic             q_enq_q, q_enq_d;
  logic             word_ack_q, word_ack_d;
  logic             q_deq_q, q_deq_d;
  logic             word_valid_q, word_valid_d;
  logic [WIDTH-1:0] q_data_q, q_data_d;
  logic [WIDTH-1:0] word_q, word_d;

  logic enq_ok;
  logic deq_ok;

  assign enq_ok = word_valid_in && (q_len_in < LEN_FULL);
  assign deq_ok = deq_pend_q && (q_len_in != 8'd0);

  // Back-pressure follows the queue length directly, even in reset.
  assign ser_busy_out = (q_len_in >= LEN_FULL);

  // State register: FSM, dequeue timer, pending flag, arbitration history.
  always_ff @(posedge clock_10) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      deq_pend_q <= 1'b0;
      last_enq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      deq_pend_q <= deq_pend_d;
      last_enq_q <= last_enq_d;
    end
  end

  // Next state: timer advance, eligibility and round-robin grant.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    deq_pend_d = deq_pend_q;
    last_enq_d = last_enq_q;

    if (drain_en_in && !deq_pend_q) begin
      if (timer_q == TMR_LAST) begin
        timer_d    = '0;
        deq_pend_d = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enq_ok && (!deq_ok || !last_enq_q)) begin
          state_d    = S_ENQ;
          last_enq_d = 1'b1;
        end else if (deq_ok) begin
          state_d    = S_DEQ;
          last_enq_d = 1'b0;
        end
      end
      S_ENQ:    state_d = S_SETTLE;
      S_DEQ: begin
        state_d    = S_SETTLE;
        deq_pend_d = 1'b0;
      end
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every strobe lines up with its state.
  always_comb begin
    q_enq_d      = 1'b0;
    word_ack_d   = 1'b0;
    q_deq_d      = 1'b0;
    word_valid_d = 1'b0;
    q_data_d     = q_data_q;
    word_d       = word_q;

    if (state_d == S_ENQ) begin
      q_enq_d    = 1'b1;
      word_ack_d = 1'b1;
    end
    if ((state_q == S_IDLE) && (state_d == S_ENQ)) begin
      q_data_d = word_in;
    end
    if (state_d == S_DEQ) begin
      q_deq_d = 1'b1;
    end
    if (state_q == S_DEQ) begin
      word_d       = q_data_in;
      word_valid_d = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clock_10) begin
    if (!reset) begin
      q_enq_q      <= 1'b0;
      word_ack_q   <= 1'b0;
      q_deq_q      <= 1'b0;
      word_valid_q <= 1'b0;
      q_data_q     <= '0;
      word_q       <= '0;
    end else begin
      q_enq_q      <= q_enq_d;
      word_ack_q   <= word_ack_d;
      q_deq_q      <= q_deq_d;
      word_valid_q <= word_valid_d;
      q_data_q     <= q_data_d;
      word_q       <= word_d;
    end
  end

  assign q_enq_out      = q_enq_q;
  assign word_ack_out   = word_ack_q;
  assign q_deq_out      = q_deq_q;
  assign word_valid_out = word_valid_q;
  assign q_data_out     = q_data_q;
  assign word_out       = word_q;

endmodule
